// File: rtl/addr_queue_ctrl_pkg.sv
// Shared constants and types for the two-port address queue controller.
package addr_queue_ctrl_pkg;

  localparam int unsigned DW         = 11;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned OBUF_DEPTH = 2;

  // Which enqueue port the round-robin arbiter currently favours.
  typedef enum logic {
    PrioEnq0 = 1'b0,
    PrioEnq1 = 1'b1
  } prio_e;

endpackage

// File: rtl/addr1_0_ext.sv
// Two-port RAM macro: one synchronous write port, one synchronous registered read port.
module addr1_0_ext
  import addr_queue_ctrl_pkg::*;
#(
  parameter int unsigned DW    = addr_queue_ctrl_pkg::DW,
  parameter int unsigned DEPTH = addr_queue_ctrl_pkg::DEPTH
) (
  input  logic [$clog2(DEPTH)-1:0] R0_addr,
  input  logic                     R0_en,
  input  logic                     R0_clk,
  output logic [DW-1:0]            R0_data,
  input  logic [$clog2(DEPTH)-1:0] W0_addr,
  input  logic                     W0_en,
  input  logic                     W0_clk,
  input  logic [DW-1:0]            W0_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge W0_clk) begin
    if (W0_en) mem[W0_addr] <= W0_data;
  end

  always_ff @(posedge R0_clk) begin
    if (R0_en) rdata_q <= mem[R0_addr];
  end

  assign R0_data = rdata_q;

endmodule

// File: rtl/addr_queue_ctrl.sv
// Two-producer, one-consumer queue: round-robin enqueue into a RAM, prefetched
// into a 2-entry output buffer so a 1-cycle-latency RAM still sustains 1 entry/cycle.
module addr_queue_ctrl
  import addr_queue_ctrl_pkg::*;
#(
  parameter int unsigned DW    = addr_queue_ctrl_pkg::DW,
  parameter int unsigned DEPTH = addr_queue_ctrl_pkg::DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq0_valid,
  input  logic [DW-1:0]    enq0_bits,
  output logic             enq0_ready,
  input  logic             enq1_valid,
  input  logic [DW-1:0]    enq1_bits,
  output logic             enq1_ready,
  output logic             deq_valid,
  output logic [DW-1:0]    deq_bits,
  input  logic             deq_ready,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned RCW = AW + 1;

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [RCW-1:0] ram_cnt_q, ram_cnt_d, occupied;
  logic           inflight_q, inflight_d;
  logic [1:0]     obuf_cnt_q, obuf_cnt_d;
  logic           obuf_head_q, obuf_head_d, obuf_tail;
  logic [DW-1:0]  obuf_q [OBUF_DEPTH];
  prio_e          prio_q, prio_d;

  logic          space, grant0, grant1, fire0, fire1, enq_fire, deq_fire, rd_issue;
  logic [2:0]    pending;
  logic [DW-1:0] enq_data, ram_rdata;

  // A slot stays occupied while its read is in flight, so writes never race it.
  assign occupied = ram_cnt_q + RCW'(inflight_q);
  assign space    = occupied < RCW'(DEPTH);

  assign grant0 = enq0_valid && (prio_q == PrioEnq0 || !enq1_valid);
  assign grant1 = enq1_valid && (prio_q == PrioEnq1 || !enq0_valid);

  assign enq0_ready = grant0 && space && !flush;
  assign enq1_ready = grant1 && space && !flush;
  assign fire0      = enq0_valid && enq0_ready;
  assign fire1      = enq1_valid && enq1_ready;
  assign enq_fire   = fire0 || fire1;
  assign enq_data   = fire0 ? enq0_bits : enq1_bits;

  assign deq_valid = (obuf_cnt_q != 2'd0) && !flush;
  assign deq_bits  = (obuf_cnt_q != 2'd0) ? obuf_q[obuf_head_q] : '0;
  assign deq_fire  = deq_valid && deq_ready;

  // Only issue a read if the buffer will still have room when its data lands.
  assign pending  = 3'(obuf_cnt_q) + 3'(inflight_q) - 3'(deq_fire);
  assign rd_issue = (ram_cnt_q != '0) && !flush && (pending <= 3'd1);

  assign obuf_tail = obuf_head_q ^ obuf_cnt_q[0];

  assign count = CNT_W'(ram_cnt_q) + CNT_W'(inflight_q) + CNT_W'(obuf_cnt_q);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    inflight_d  = inflight_q;
    obuf_cnt_d  = obuf_cnt_q;
    obuf_head_d = obuf_head_q;
    prio_d      = prio_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_cnt_d   = '0;
      inflight_d  = 1'b0;
      obuf_cnt_d  = 2'd0;
      obuf_head_d = 1'b0;
    end else begin
      if (enq_fire) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        prio_d   = fire0 ? PrioEnq1 : PrioEnq0;
      end
      if (rd_issue) rd_ptr_d = rd_ptr_q + AW'(1);
      ram_cnt_d  = ram_cnt_q + RCW'(enq_fire) - RCW'(rd_issue);
      inflight_d = rd_issue;
      obuf_cnt_d = obuf_cnt_q + 2'(inflight_q) - 2'(deq_fire);
      if (deq_fire) obuf_head_d = ~obuf_head_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      obuf_cnt_q  <= 2'd0;
      obuf_head_q <= 1'b0;
      prio_q      <= PrioEnq0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      inflight_q  <= inflight_d;
      obuf_cnt_q  <= obuf_cnt_d;
      obuf_head_q <= obuf_head_d;
      prio_q      <= prio_d;
    end
  end

  // Buffer storage needs no reset: deq_bits is masked whenever the buffer is empty.
  always_ff @(posedge clock) begin
    if (inflight_q && !flush) obuf_q[obuf_tail] <= ram_rdata;
  end

  addr1_0_ext #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .R0_addr (rd_ptr_q),
    .R0_en   (rd_issue),
    .R0_clk  (clock),
    .R0_data (ram_rdata),
    .W0_addr (wr_ptr_q),
    .W0_en   (enq_fire),
    .W0_clk  (clock),
    .W0_data (enq_data)
  );

endmodule

// File: tb/tb_addr_queue_ctrl.sv
// Directed bench for addr_queue_ctrl: hand-computed expectations checked with immediate asserts.
module tb_addr_queue_ctrl;

  logic        clock = 1'b0;
  logic        reset, flush;
  logic        enq0_valid, enq0_ready, enq1_valid, enq1_ready;
  logic [10:0] enq0_bits, enq1_bits, deq_bits;
  logic        deq_valid, deq_ready;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  addr_queue_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .enq0_valid (enq0_valid),
    .enq0_bits  (enq0_bits),
    .enq0_ready (enq0_ready),
    .enq1_valid (enq1_valid),
    .enq1_bits  (enq1_bits),
    .enq1_ready (enq1_ready),
    .deq_valid  (deq_valid),
    .deq_bits   (deq_bits),
    .deq_ready  (deq_ready),
    .count      (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Alternating-grant order: 0x100, 0x200, 0x101, 0x201, ...
  function automatic int alt_exp(input int k);
    return (k % 2 == 0) ? ('h100 + k / 2) : ('h200 + k / 2);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; deq_ready = 1'b0;
    enq0_valid = 1'b0; enq1_valid = 1'b0; enq0_bits = '0; enq1_bits = '0;
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_deq_valid", 32'(deq_valid), 0);
    check("rst_deq_bits", 32'(deq_bits), 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Single enqueue, latency 3
    next_cycle();
    enq0_valid = 1'b1; enq0_bits = 11'h5A3; deq_ready = 1'b1;
    @(negedge clock);
    check("t1_ready", 32'(enq0_ready), 1);
    check("t1_count_c0", 32'(count), 0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      enq0_valid = 1'b0;
      @(negedge clock);
      check("t1_count", 32'(count), (c <= 3) ? 1 : 0);
      check("t1_deq_valid", 32'(deq_valid), 32'(c == 3));
      if (c == 3) check("t1_deq_bits", 32'(deq_bits), 'h5A3);
    end

    // Reset pulse returns prio to enq0
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;

    // Both ports valid, alternating grants, steady one/cycle
    for (int cyc = 0; cyc < 12; cyc++) begin
      next_cycle();
      enq0_valid = (cyc < 8);
      enq1_valid = (cyc < 8);
      enq0_bits  = 11'('h100 + (cyc + 1) / 2);
      enq1_bits  = 11'('h200 + cyc / 2);
      @(negedge clock);
      if (cyc < 8) begin
        check("t2_ready0", 32'(enq0_ready), 32'(cyc % 2 == 0));
        check("t2_ready1", 32'(enq1_ready), 32'(cyc % 2 == 1));
      end
      check("t2_deq_valid", 32'(deq_valid), 32'(cyc >= 3 && cyc <= 10));
      if (cyc >= 3 && cyc <= 10) check("t2_deq_bits", 32'(deq_bits), alt_exp(cyc - 3));
    end

    // Fill to full with deq_ready low: 10 of 12 accepted
    enq1_valid = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      next_cycle();
      deq_ready  = 1'b0;
      enq0_valid = 1'b1;
      enq0_bits  = 11'('h300 + cyc);
      @(negedge clock);
      check("t3_ready", 32'(enq0_ready), 32'(cyc < 10));
      if (cyc >= 10) check("t3_count_full", 32'(count), 10);
    end
    next_cycle();
    enq0_bits = 11'h3FF; deq_ready = 1'b1;
    @(negedge clock);
    check("t3_full_ready_with_deq", 32'(enq0_ready), 0);
    check("t3_deq_valid", 32'(deq_valid), 1);
    check("t3_deq_bits", 32'(deq_bits), 'h300);
    for (int k = 1; k < 10; k++) begin
      next_cycle();
      enq0_valid = 1'b0;
      @(negedge clock);
      check("t3_drain_valid", 32'(deq_valid), 1);
      check("t3_drain_bits", 32'(deq_bits), 'h300 + k);
    end
    next_cycle();
    @(negedge clock);
    check("t3_empty_valid", 32'(deq_valid), 0);
    check("t3_empty_count", 32'(count), 0);

    // Flush with 5 entries and a read in flight
    for (int cyc = 0; cyc < 5; cyc++) begin
      next_cycle();
      deq_ready  = 1'b0;
      enq0_valid = 1'b1;
      enq0_bits  = 11'('h400 + cyc);
      @(negedge clock);
      check("t4_ready", 32'(enq0_ready), 1);
    end
    next_cycle();
    enq0_bits = 11'h405; deq_ready = 1'b1;
    @(negedge clock);
    check("t4_count5", 32'(count), 5);
    check("t4_deq_bits", 32'(deq_bits), 'h400);
    next_cycle();
    flush = 1'b1; enq0_bits = 11'h4AA;
    @(negedge clock);
    check("t4_flush_count", 32'(count), 5);
    check("t4_flush_deq_valid", 32'(deq_valid), 0);
    check("t4_flush_ready", 32'(enq0_ready), 0);
    next_cycle();
    flush = 1'b0; enq0_bits = 11'h7FF;
    @(negedge clock);
    check("t4_post_count", 32'(count), 0);
    check("t4_post_deq_valid", 32'(deq_valid), 0);
    check("t4_post_ready", 32'(enq0_ready), 1);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      enq0_valid = 1'b0;
      @(negedge clock);
      check("t4_deq_valid", 32'(deq_valid), 32'(c == 3));
      check("t4_count", 32'(count), (c <= 3) ? 1 : 0);
      if (c == 3) check("t4_deq_bits", 32'(deq_bits), 'h7FF);
    end

    // Reset mid-stream for two cycles
    for (int cyc = 0; cyc < 3; cyc++) begin
      next_cycle();
      enq1_valid = 1'b1;
      enq1_bits  = 11'('h500 + cyc);
      @(negedge clock);
      check("t5_ready1", 32'(enq1_ready), 1);
    end
    next_cycle();
    enq1_valid = 1'b0;
    #1;
    check("t5_pre_valid", 32'(deq_valid), 1);
    check("t5_pre_bits", 32'(deq_bits), 'h500);
    reset = 1'b1;
    #1;
    check("t5_rst_count", 32'(count), 0);
    check("t5_rst_valid", 32'(deq_valid), 0);
    check("t5_rst_bits", 32'(deq_bits), 0);
    next_cycle();
    @(negedge clock);
    check("t5_rst_hold_count", 32'(count), 0);
    next_cycle();
    reset = 1'b0;
    enq0_valid = 1'b1; enq0_bits = 11'h001;
    @(negedge clock);
    check("t5_ready0", 32'(enq0_ready), 1);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      enq0_valid = 1'b0;
      @(negedge clock);
      check("t5_deq_valid", 32'(deq_valid), 32'(c == 3));
      check("t5_count", 32'(count), (c <= 3) ? 1 : 0);
      if (c == 3) check("t5_deq_bits", 32'(deq_bits), 'h001);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
